button_mode_ctrl: RTL and testbench

BUTTON_MODE_CTRL -- requirements
Module: button_mode_ctrl

---
 rtl/button_mode_ctrl.sv | 171 +++++++++++++++++
 tb/tb_button_mode_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/button_mode_ctrl.sv
// Two-button mode controller: synchronizes and debounces raw buttons,
// steps RUN/SET_* modes and emits increment pulses with auto-repeat.
module button_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clock,
  input  logic       our_reset,
  input  logic       counter_trigger,
  input  logic       increment_trigger,
  output logic [1:0] mode,
  output logic       mode_led_output,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour
);

  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW = $clog2(RMAX + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } mode_e;

  // bit 0: counter button, bit 1: increment button
  logic [1:0]      s1_q, s2_q;
  logic [1:0]      lvl_q, lvl_d;
  logic [1:0]      prv_q;
  logic [1:0][7:0] db_q, db_d;
  logic [1:0]      rise;

  mode_e           mode_q, mode_d;
  logic            led_q, led_d;
  logic [2:0]      inc_q, inc_d;
  logic            rep_on_q, rep_on_d;
  logic            rep_ph_q, rep_ph_d;
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [IW-1:0]   idle_q, idle_d;

  logic            set_mode;
  logic            pulse;
  logic            rep_hit;
  logic            tmo;

  always_comb begin
    db_d  = db_q;
    lvl_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == lvl_q[i]) begin
        db_d[i] = '0;
      end else if (db_q[i] >= 8'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d[i] = s2_q[i];
        db_d[i]  = '0;
      end else begin
        db_d[i] = db_q[i] + 8'd1;
      end
    end
  end

  assign rise     = lvl_q & ~prv_q;
  assign set_mode = (mode_q != RUN);

  always_comb begin
    mode_d    = mode_q;
    inc_d     = 3'b000;
    rep_on_d  = rep_on_q;
    rep_ph_d  = rep_ph_q;
    rep_cnt_d = rep_cnt_q;
    idle_d    = idle_q;
    pulse     = 1'b0;
    tmo       = 1'b0;
    rep_hit   = rep_ph_q ?
                (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) :
                (rep_cnt_q == RW'(HOLD_CYCLES - 1));

    if (rise[1] && set_mode) begin
      pulse     = 1'b1;
      rep_on_d  = 1'b1;
      rep_ph_d  = 1'b0;
      rep_cnt_d = '0;
    end else if (rep_on_q && lvl_q[1] && set_mode) begin
      if (rep_hit) begin
        pulse     = 1'b1;
        rep_ph_d  = 1'b1;
        rep_cnt_d = '0;
      end else if (rep_cnt_q != '1) begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end else begin
      rep_on_d  = 1'b0;
      rep_ph_d  = 1'b0;
      rep_cnt_d = '0;
    end

    if (pulse) begin
      unique case (mode_q)
        SET_SEC:  inc_d = 3'b001;
        SET_MIN:  inc_d = 3'b010;
        SET_HOUR: inc_d = 3'b100;
        default:  inc_d = 3'b000;
      endcase
    end

    if (!set_mode || rise[0] || rise[1] || pulse) begin
      idle_d = '0;
    end else if (idle_q >= IW'(TIMEOUT_CYCLES - 1)) begin
      tmo    = 1'b1;
      idle_d = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    // Increment above used the pre-advance mode; now step or time out.
    if (rise[0]) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end else if (tmo) begin
      mode_d = RUN;
    end
    if (mode_d != mode_q) begin
      rep_on_d  = 1'b0;
      rep_ph_d  = 1'b0;
      rep_cnt_d = '0;
    end

    led_d = (mode_d != RUN);
  end

  always_ff @(posedge clock) begin
    if (our_reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      lvl_q     <= '0;
      prv_q     <= '0;
      db_q      <= '0;
      mode_q    <= RUN;
      led_q     <= 1'b0;
      inc_q     <= 3'b000;
      rep_on_q  <= 1'b0;
      rep_ph_q  <= 1'b0;
      rep_cnt_q <= '0;
      idle_q    <= '0;
    end else begin
      s1_q      <= {increment_trigger, counter_trigger};
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      prv_q     <= lvl_q;
      db_q      <= db_d;
      mode_q    <= mode_d;
      led_q     <= led_d;
      inc_q     <= inc_d;
      rep_on_q  <= rep_on_d;
      rep_ph_q  <= rep_ph_d;
      rep_cnt_q <= rep_cnt_d;
      idle_q    <= idle_d;
    end
  end

  assign mode            = mode_q;
  assign mode_led_output = led_q;
  assign inc_sec         = inc_q[0];
  assign inc_min         = inc_q[1];
  assign inc_hour        = inc_q[2];

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Directed bench for button_mode_ctrl: mode stepping, routing,
// simultaneous edges, auto-repeat, timeout and reset behaviour.
module tb_button_mode_ctrl;

  logic       clock = 1'b0;
  logic       our_reset = 1'b1;
  logic       counter_trigger = 1'b0;
  logic       increment_trigger = 1'b0;
  logic [1:0] mode;
  logic       mode_led_output;
  logic       inc_sec, inc_min, inc_hour;

  int checks = 0;
  int failures = 0;
  int n_sec = 0, n_min = 0, n_hour = 0, n_multi = 0;
  int cyc = 0;
  int sec_t[$];

  button_mode_ctrl dut (
    .clock(clock),
    .our_reset(our_reset),
    .counter_trigger(counter_trigger),
    .increment_trigger(increment_trigger),
    .mode(mode),
    .mode_led_output(mode_led_output),
    .inc_sec(inc_sec),
    .inc_min(inc_min),
    .inc_hour(inc_hour)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    cyc++;
    if (inc_sec) begin
      n_sec++;
      sec_t.push_back(cyc);
    end
    if (inc_min) n_min++;
    if (inc_hour) n_hour++;
    if (int'(inc_sec) + int'(inc_min) + int'(inc_hour) > 1) n_multi++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_sec = 0;
    n_min = 0;
    n_hour = 0;
    sec_t.delete();
  endtask

  // One-cycle raw pulse; returns two negedges after the sampling edge.
  task automatic press(input logic c, input logic i);
    @(negedge clock);
    counter_trigger = c;
    increment_trigger = i;
    @(negedge clock);
    counter_trigger = 1'b0;
    increment_trigger = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic step_mode();
    press(1'b1, 1'b0);
    @(negedge clock);
  endtask

  int exp_rel[7] = '{0, 8, 12, 16, 20, 24, 28};

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_mode", mode, 0);
    chk("rst_led", mode_led_output, 0);
    chk("rst_inc", {inc_hour, inc_min, inc_sec}, 0);
    our_reset = 1'b0;
    @(negedge clock);

    // mode cycle with exact 3-cycle latency
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0);
      chk($sformatf("cyc_pre%0d", i), mode, i);
      @(negedge clock);
      chk($sformatf("cyc_mode%0d", i), mode, (i + 1) % 4);
      chk($sformatf("cyc_led%0d", i), mode_led_output, (i < 3) ? 1 : 0);
    end

    // increment routing
    for (int m = 0; m < 4; m++) begin
      clr();
      press(1'b0, 1'b1);
      repeat (3) @(negedge clock);
      chk($sformatf("rt_sec%0d", m), n_sec, (m == 1) ? 1 : 0);
      chk($sformatf("rt_min%0d", m), n_min, (m == 2) ? 1 : 0);
      chk($sformatf("rt_hour%0d", m), n_hour, (m == 3) ? 1 : 0);
      step_mode();
      chk($sformatf("rt_mode%0d", m), mode, (m + 1) % 4);
    end

    // simultaneous edges in SET_MIN
    step_mode();
    step_mode();
    chk("sim_pre", mode, 2);
    clr();
    press(1'b1, 1'b1);
    chk("sim_mode_pre", mode, 2);
    @(negedge clock);
    chk("sim_mode", mode, 3);
    chk("sim_inc_min", inc_min, 1);
    repeat (3) @(negedge clock);
    chk("sim_n_min", n_min, 1);
    chk("sim_n_other", n_sec + n_hour, 0);
    step_mode();
    chk("sim_back", mode, 0);

    // auto-repeat in SET_SEC, 30-cycle hold
    step_mode();
    chk("rep_mode", mode, 1);
    clr();
    @(negedge clock);
    increment_trigger = 1'b1;
    repeat (30) @(negedge clock);
    increment_trigger = 1'b0;
    repeat (20) @(negedge clock);
    chk("rep_count", sec_t.size(), 7);
    if (sec_t.size() == 7)
      for (int k = 0; k < 7; k++)
        chk($sformatf("rep_t%0d", k), sec_t[k] - sec_t[0], exp_rel[k]);
    chk("rep_other", n_min + n_hour, 0);

    // timeout from a fresh SET_SEC entry
    step_mode();
    step_mode();
    step_mode();
    clr();
    step_mode();
    chk("to_enter", mode, 1);
    repeat (63) @(negedge clock);
    chk("to_pre", mode, 1);
    @(negedge clock);
    chk("to_mode", mode, 0);
    chk("to_led", mode_led_output, 0);
    chk("to_inc", n_sec + n_min + n_hour, 0);

    // reset during a repeat in SET_HOUR
    step_mode();
    step_mode();
    step_mode();
    chk("rr_mode", mode, 3);
    clr();
    @(negedge clock);
    increment_trigger = 1'b1;
    repeat (13) @(negedge clock);
    chk("rr_before", n_hour, 2);
    clr();
    our_reset = 1'b1;
    @(negedge clock);
    chk("rr_rst_mode", mode, 0);
    chk("rr_rst_hour", inc_hour, 0);
    @(negedge clock);
    our_reset = 1'b0;
    repeat (10) @(negedge clock);
    increment_trigger = 1'b0;
    repeat (5) @(negedge clock);
    chk("rr_after", n_hour, 0);
    chk("rr_mode_after", mode, 0);

    // button held through reset counts as a new edge
    @(negedge clock);
    our_reset = 1'b1;
    counter_trigger = 1'b1;
    repeat (2) @(negedge clock);
    our_reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("hold_pre", mode, 0);
    @(negedge clock);
    chk("hold_mode", mode, 1);
    chk("hold_led", mode_led_output, 1);
    counter_trigger = 1'b0;
    repeat (5) @(negedge clock);
    chk("one_hot", n_multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
